act7_2by1_b: RTL and testbench

2:1 multiplexer block, built at gate level, with a combinational select path and a registered copy of the result. It selects D1 when S=1 and D0 when S=0. It is the basic selector primitive for the ACT7 multiplexer family; wider muxes (4:1, 8:1) are composed from it. The combinational output serves unclocked contexts, and the registered output serves pipelined datapaths.

---
 rtl/act7_pkg.sv | 14 +
 rtl/act7_mux2_bit.sv | 27 ++
 rtl/act7_2by1_b.sv | 53 +++++
 tb/tb_act7_2by1_b.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/act7_pkg.sv
// rtl/act7_pkg.sv - shared constants for the ACT7 multiplexer family
//
// Purpose : width default and select encodings reused by act7_2by1_b and the
//           wider ACT7 muxes composed from it.
// Ports   : none (package).
package act7_pkg;

    localparam int ACT7_DEFAULT_WIDTH = 1;

    // Select encoding: S=SEL_D0 routes D0, S=SEL_D1 routes D1.
    localparam logic SEL_D0 = 1'b0;
    localparam logic SEL_D1 = 1'b1;

endpackage

// File: rtl/act7_mux2_bit.sv
// rtl/act7_mux2_bit.sv - 1-bit gate-level 2:1 multiplexer slice
//
// Purpose : y = (d1 & s) | (d0 & ~s), built from NOT/AND/AND/OR primitives so
//           the netlist matches the select equation gate for gate.
// Ports   : i_d1 - data selected when i_s=1
//           i_d0 - data selected when i_s=0
//           i_s  - select
//           o_y  - combinational result
module act7_mux2_bit
    import act7_pkg::*;
(
    input  logic i_d1,
    input  logic i_d0,
    input  logic i_s,
    output logic o_y
);

    logic w_s_n;
    logic w_and_d1;
    logic w_and_d0;

    not u_not_s  (w_s_n,    i_s);
    and u_and_d1 (w_and_d1, i_d1, i_s);
    and u_and_d0 (w_and_d0, i_d0, w_s_n);
    or  u_or_y   (o_y,      w_and_d1, w_and_d0);

endmodule

// File: rtl/act7_2by1_b.sv
// rtl/act7_2by1_b.sv - WIDTH-bit 2:1 mux with combinational and registered outputs
//
// Purpose : Y = D1 when S=1, else D0, formed by WIDTH gate-level slices sharing
//           one select line; Y_R is Y captured on each rising clk edge.
// Ports   : clk - rising-edge clock, used only by the output register
//           rst - synchronous active-high reset, clears Y_R only
//           Y   - combinational result (WIDTH)
//           D1  - data selected when S=1 (WIDTH)
//           D0  - data selected when S=0 (WIDTH)
//           S   - select, broadcast to every bit
//           Y_R - Y registered, one-cycle latency (WIDTH)
module act7_2by1_b
    import act7_pkg::*;
#(
    parameter int WIDTH = ACT7_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D0,
    input  logic             S,
    output logic [WIDTH-1:0] Y_R
);

    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_y_r;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_slice
            act7_mux2_bit u_bit (
                .i_d1 (D1[g]),
                .i_d0 (D0[g]),
                .i_s  (S),
                .o_y  (w_y[g])
            );
        end
    endgenerate

    // Reset touches only the register; Y keeps tracking inputs during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_r <= '0;
        end else begin
            r_y_r <= w_y;
        end
    end

    assign Y   = w_y;
    assign Y_R = r_y_r;

endmodule

// File: tb/tb_act7_2by1_b.sv
// tb/tb_act7_2by1_b.sv - self-checking bench for act7_2by1_b at WIDTH=1 and WIDTH=8
`timescale 1ns/100ps
module tb_act7_2by1_b;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       s1, s8;
    logic [0:0] d0_1, d1_1, y_1, yr_1;
    logic [7:0] d0_8, d1_8, y_8, yr_8;

    int errors;
    int checks;

    logic [7:0] q1[$];
    logic [7:0] q8[$];

    act7_2by1_b #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .Y   (y_1),
        .D1  (d1_1),
        .D0  (d0_1),
        .S   (s1),
        .Y_R (yr_1)
    );

    act7_2by1_b #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .Y   (y_8),
        .D1  (d1_8),
        .D0  (d0_8),
        .S   (s8),
        .Y_R (yr_8)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    function automatic logic [7:0] mux_model(logic [7:0] d0, logic [7:0] d1, logic s);
        return s ? d1 : d0;
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Push the expected register contents for the current inputs, clock once,
    // then pop and compare both instances just after the edge.
    task automatic cyc(string tag);
        logic [7:0] e1;
        logic [7:0] e8;
        q1.push_back(rst ? 8'h00 : (mux_model({7'd0, d0_1}, {7'd0, d1_1}, s1) & 8'h01));
        q8.push_back(rst ? 8'h00 : mux_model(d0_8, d1_8, s8));
        @(posedge clk);
        #1;
        if (q1.size() == 0 || q8.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard_empty observed=%0d expected=1", tag, q1.size());
        end else begin
            e1 = q1.pop_front();
            e8 = q8.pop_front();
            chk({tag, "_w1"}, {7'd0, yr_1}, e1);
            chk({tag, "_w8"}, yr_8, e8);
        end
    endtask

    initial begin
        logic [2:0] v;
        logic [7:0] sweep_exp;
        errors    = 0;
        checks    = 0;
        clk_run   = 1'b0;
        sweep_exp = 8'b1010_1100; // Y for (S,D0,D1)=000..111, LSB first
        rst  = 1'b0;
        s1   = 1'b0; d0_1 = 1'b0; d1_1 = 1'b0;
        s8   = 1'b0; d0_8 = 8'h00; d1_8 = 8'h00;
        #1;

        // Exhaustive combinational sweep with the clock stopped.
        for (int i = 0; i < 8; i++) begin
            v    = i[2:0];
            s1   = v[2];
            d0_1 = v[1];
            d1_1 = v[0];
            #0.1;
            chk($sformatf("sweep_%0d", i), {7'd0, y_1}, {7'd0, sweep_exp[i]});
            #0.9;
        end

        clk_run = 1'b1;

        // Reset: register cleared while Y still follows inputs.
        @(negedge clk);
        rst = 1'b1; s1 = 1'b1; d1_1 = 1'b1; d0_1 = 1'b0;
        s8 = 1'b0; d0_8 = 8'h5A; d1_8 = 8'h00;
        cyc("reset");
        chk("reset_y_w1", {7'd0, y_1}, 8'h01);
        chk("reset_y_w8", y_8, 8'h5A);
        @(negedge clk);
        rst = 1'b0;
        cyc("reset_release");

        // Registered latency sequence: Y_R 1,0,1,0.
        @(negedge clk); s1 = 1'b0; d0_1 = 1'b1; cyc("lat1");
        chk("lat1_val", {7'd0, yr_1}, 8'h01);
        @(negedge clk); s1 = 1'b1; d1_1 = 1'b0; cyc("lat2");
        chk("lat2_val", {7'd0, yr_1}, 8'h00);
        @(negedge clk); s1 = 1'b1; d1_1 = 1'b1; cyc("lat3");
        chk("lat3_val", {7'd0, yr_1}, 8'h01);
        @(negedge clk); s1 = 1'b0; d0_1 = 1'b0; cyc("lat4");
        chk("lat4_val", {7'd0, yr_1}, 8'h00);

        // Wide data.
        @(negedge clk);
        d0_8 = 8'hA5; d1_8 = 8'h3C; s8 = 1'b0;
        #0.1;
        chk("wide_y_s0", y_8, 8'hA5);
        cyc("wide_s0");
        chk("wide_yr_s0", yr_8, 8'hA5);
        @(negedge clk);
        s8 = 1'b1;
        #0.1;
        chk("wide_y_s1", y_8, 8'h3C);
        cyc("wide_s1");
        chk("wide_yr_s1", yr_8, 8'h3C);

        // Mid-stream reset.
        @(negedge clk); s8 = 1'b0; d0_8 = 8'hFF; cyc("mid_load");
        chk("mid_load_val", yr_8, 8'hFF);
        @(negedge clk); rst = 1'b1; cyc("mid_rst");
        chk("mid_rst_val", yr_8, 8'h00);
        chk("mid_rst_y", y_8, 8'hFF);
        @(negedge clk); rst = 1'b0; cyc("mid_release");
        chk("mid_release_val", yr_8, 8'hFF);

        // Select toggling every cycle.
        @(negedge clk);
        d0_8 = 8'h00; d1_8 = 8'hFF; d0_1 = 1'b0; d1_1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s8 = i[0];
            s1 = i[0];
            cyc($sformatf("toggle_%0d", i));
            chk($sformatf("toggle_val_%0d", i), yr_8, i[0] ? 8'hFF : 8'h00);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
